inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 16 +
 rtl/pc_reg.sv | 34 +++
 rtl/inst_fetch.sv | 131 +++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared CPU defines for the instruction fetch stage.
// Holds the default datapath width, the default reset PC and the fetch FSM
// state encoding. inst_fetch and pc_reg both import this package.
package inst_fetch_pkg;

  localparam int          IF_W        = 16;
  localparam logic [15:0] IF_RESET_PC = 16'h0000;

  // REQ  : a read request is outstanding on the instruction memory port.
  // HOLD : a fetched instruction is presented to decode.
  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } if_state_e;

endpackage

// File: rtl/pc_reg.sv
// Architectural program counter register.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset (reset to RESET_PC)
//   load      - load load_val into the PC (has priority over inc)
//   load_val  - value loaded when load=1
//   inc       - increment the PC by one, wrapping modulo 2^W
//   q         - current PC
module pc_reg
  import inst_fetch_pkg::*;
#(
  parameter int          W        = IF_W,
  parameter logic [W-1:0] RESET_PC = W'(IF_RESET_PC)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] q
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= load_val;
    end else if (inc) begin
      q <= q + W'(1); // wraps naturally at 2^W
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage.
// A two-state FSM alternates between requesting a word from instruction
// memory (REQ) and presenting it to decode (HOLD). A redirect that arrives
// while a request is outstanding is remembered in flush_pend/pend_pc, and the
// word returned for the stale request is dropped.
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   redirect_valid/redirect_pc - taken jump/branch and its target
//   imem_req/imem_addr         - instruction memory read request and address
//   imem_ack/imem_rdata        - request completion and returned word
//   inst_valid/inst/inst_pc    - fetched instruction presented to decode
//   inst_ready                 - decode accepts inst this cycle
//   pc                         - address of the next fetch
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          W        = IF_W,
  parameter logic [W-1:0] RESET_PC = W'(IF_RESET_PC)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect_valid,
  input  logic [W-1:0] redirect_pc,
  output logic         imem_req,
  output logic [W-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [W-1:0] imem_rdata,
  output logic         inst_valid,
  output logic [W-1:0] inst,
  output logic [W-1:0] inst_pc,
  input  logic         inst_ready,
  output logic [W-1:0] pc
);

  if_state_e    state_q, state_d;
  logic         flush_pend;
  logic [W-1:0] pend_pc;

  logic         pc_load;
  logic         pc_inc;
  logic [W-1:0] pc_load_val;
  logic         capture;
  logic         flush_set;
  logic         flush_clr;
  logic         transfer;

  pc_reg #(
    .W        (W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .q        (pc)
  );

  // Outputs come straight from the state register, so imem_req and
  // inst_valid are mutually exclusive by construction.
  assign imem_req   = (state_q == ST_REQ);
  assign inst_valid = (state_q == ST_HOLD);
  assign imem_addr  = pc; // pc only changes on the ack edge while in REQ
  assign transfer   = inst_valid & inst_ready & ~redirect_valid;

  // NOTE: every signal driven here gets a default first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load_val = redirect_pc;
    capture     = 1'b0;
    flush_set   = 1'b0;
    flush_clr   = 1'b0;
    unique case (state_q)
      ST_REQ: begin
        if (imem_ack) begin
          if (redirect_valid || flush_pend) begin
            // Returned word belongs to the abandoned path: drop it and
            // restart at the newest redirect target.
            pc_load     = 1'b1;
            pc_load_val = redirect_valid ? redirect_pc : pend_pc;
            flush_clr   = 1'b1;
          end else begin
            capture = 1'b1;
            pc_inc  = 1'b1;
            state_d = ST_HOLD;
          end
        end else if (redirect_valid) begin
          flush_set = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          // Held instruction is discarded even if decode was ready.
          pc_load = 1'b1;
          state_d = ST_REQ;
        end else if (transfer) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // NOTE: all control and datapath registers here take the asynchronous
  // reset, so an ack arriving while rst=1 cannot update anything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_REQ;
      flush_pend <= 1'b0;
      pend_pc    <= '0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      state_q <= state_d;
      if (flush_set) begin
        flush_pend <= 1'b1;
        pend_pc    <= redirect_pc; // a later redirect overwrites the target
      end else if (flush_clr) begin
        flush_pend <= 1'b0;
      end
      if (capture) begin
        inst    <= imem_rdata;
        inst_pc <= pc;
      end
    end
  end

endmodule
